// File: rtl/axi_wr_arb.sv
// axi_wr_arb: round-robin AW arbiter plus in-order W routing FIFO for one crossbar master port.
// Optional same-cycle W bypass on an empty FIFO is enabled by defining AXI_WR_ARB_W_BYPASS_EN.
module axi_wr_arb #(
  parameter int unsigned NoSlvPorts = 32'd4,
  parameter int unsigned MaxWTrans  = 32'd4,
  parameter int unsigned SelWidth   = $clog2(NoSlvPorts)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NoSlvPorts-1:0] slv_aw_valid_i,
  output logic [NoSlvPorts-1:0] slv_aw_ready_o,
  output logic                  mst_aw_valid_o,
  input  logic                  mst_aw_ready_i,
  output logic [SelWidth-1:0]   aw_sel_o,
  input  logic [NoSlvPorts-1:0] slv_w_valid_i,
  input  logic [NoSlvPorts-1:0] slv_w_last_i,
  output logic [NoSlvPorts-1:0] slv_w_ready_o,
  output logic                  mst_w_valid_o,
  output logic                  mst_w_last_o,
  input  logic                  mst_w_ready_i,
  output logic [SelWidth-1:0]   w_sel_o,
  output logic                  w_fifo_full_o,
  output logic                  w_fifo_empty_o
);

  localparam int unsigned PtrWidth = (MaxWTrans > 32'd1) ? $clog2(MaxWTrans) : 32'd1;
  localparam int unsigned CntWidth = $clog2(MaxWTrans + 32'd1);
  localparam logic [SelWidth-1:0] SelMax  = SelWidth'(NoSlvPorts - 32'd1);
  localparam logic [PtrWidth-1:0] PtrMax  = PtrWidth'(MaxWTrans - 32'd1);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(MaxWTrans);

  function automatic logic [SelWidth-1:0] sel_inc(input logic [SelWidth-1:0] v);
    sel_inc = (v == SelMax) ? {SelWidth{1'b0}} : v + 1'b1;
  endfunction

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] v);
    ptr_inc = (v == PtrMax) ? {PtrWidth{1'b0}} : v + 1'b1;
  endfunction

  logic [SelWidth-1:0] rr_q, lock_idx_q, cand, sel, idx, head, w_sel;
  logic                lock_q, any_valid, hit;
  logic [SelWidth-1:0] fifo_q [MaxWTrans];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] cnt_q;
  logic                fifo_full, fifo_empty, aw_hs, w_route, w_last_hs, push, pop;

  assign fifo_full      = (cnt_q == CntFull);
  assign fifo_empty     = (cnt_q == {CntWidth{1'b0}});
  assign head           = fifo_q[rd_ptr_q];
  assign sel            = lock_q ? lock_idx_q : cand;
  assign w_fifo_full_o  = fifo_full && !rst_i;
  assign w_fifo_empty_o = fifo_empty || rst_i;

  // Round-robin search for the first valid requester starting at rr_q
  always_comb begin
    cand      = rr_q;
    any_valid = 1'b0;
    idx       = rr_q;
    hit       = 1'b0;
    for (int unsigned i = 0; i < NoSlvPorts; i++) begin
      hit       = !any_valid && slv_aw_valid_i[idx];
      cand      = hit ? idx : cand;
      any_valid = any_valid | hit;
      idx       = sel_inc(idx);
    end
  end

  // AW channel outputs; nothing is offered while the routing FIFO is full or in reset
  always_comb begin
    slv_aw_ready_o = {NoSlvPorts{1'b0}};
    mst_aw_valid_o = 1'b0;
    aw_sel_o       = {SelWidth{1'b0}};
    if (rst_i) begin
      mst_aw_valid_o = 1'b0;
    end else begin
      mst_aw_valid_o      = any_valid && !fifo_full;
      slv_aw_ready_o[sel] = mst_aw_ready_i && !fifo_full;
      aw_sel_o            = sel;
    end
    aw_hs = mst_aw_valid_o && mst_aw_ready_i;
  end

  // W channel routing from the FIFO head (or the fresh grant when bypassing)
  always_comb begin
    w_route = 1'b0;
    w_sel   = {SelWidth{1'b0}};
    if (rst_i) begin
      w_route = 1'b0;
    end else if (!fifo_empty) begin
      w_route = 1'b1;
      w_sel   = head;
    end
`ifdef AXI_WR_ARB_W_BYPASS_EN
    else if (aw_hs) begin
      w_route = 1'b1;
      w_sel   = sel;
    end
`endif
    else begin
      w_route = 1'b0;
    end
    mst_w_valid_o        = w_route && slv_w_valid_i[w_sel];
    mst_w_last_o         = w_route && slv_w_last_i[w_sel];
    slv_w_ready_o        = {NoSlvPorts{1'b0}};
    slv_w_ready_o[w_sel] = w_route && mst_w_ready_i;
    w_sel_o              = w_sel;
    w_last_hs            = mst_w_valid_o && mst_w_ready_i && mst_w_last_o;
    // A last beat on an empty FIFO is a bypassed burst: its push and pop cancel
    pop                  = w_last_hs && !fifo_empty;
    push                 = aw_hs && !(fifo_empty && w_last_hs);
  end

  // Round-robin pointer and AW lock for valid stability under back-pressure
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= {SelWidth{1'b0}};
      lock_q     <= 1'b0;
      lock_idx_q <= {SelWidth{1'b0}};
    end else if (aw_hs) begin
      rr_q   <= sel_inc(sel);
      lock_q <= 1'b0;
    end else if (mst_aw_valid_o && !mst_aw_ready_i) begin
      lock_q     <= 1'b1;
      lock_idx_q <= sel;
    end
  end

  // Routing FIFO storing granted requester indices in grant order
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PtrWidth{1'b0}};
      rd_ptr_q <= {PtrWidth{1'b0}};
      cnt_q    <= {CntWidth{1'b0}};
      for (int unsigned i = 0; i < MaxWTrans; i++) begin
        fifo_q[i] <= {SelWidth{1'b0}};
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arb.sv
// Bench for axi_wr_arb: directed scenarios plus random traffic checked against a queue-based model.
module tb_axi_wr_arb;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  slv_aw_valid, slv_aw_ready, slv_w_valid, slv_w_last, slv_w_ready;
  logic          mst_aw_valid, mst_aw_ready, mst_w_valid, mst_w_last, mst_w_ready;
  logic          w_fifo_full, w_fifo_empty;
  logic [SW-1:0] aw_sel, w_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: outstanding grants in order, rr pointer, pending-grant lock
  int q[$];
  int rr       = 0;
  bit locked   = 1'b0;
  int lock_idx = 0;
  int e_sel;
  bit e_awv, e_awhs, e_whs;

  always #5 clk = ~clk;

  axi_wr_arb #(.NoSlvPorts(N), .MaxWTrans(D)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_aw_valid_i(slv_aw_valid), .slv_aw_ready_o(slv_aw_ready),
    .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(mst_aw_ready), .aw_sel_o(aw_sel),
    .slv_w_valid_i(slv_w_valid), .slv_w_last_i(slv_w_last), .slv_w_ready_o(slv_w_ready),
    .mst_w_valid_o(mst_w_valid), .mst_w_last_o(mst_w_last), .mst_w_ready_i(mst_w_ready),
    .w_sel_o(w_sel), .w_fifo_full_o(w_fifo_full), .w_fifo_empty_o(w_fifo_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the current inputs, derived from the arbitration rules
  task automatic model_check();
    logic [N-1:0] e_awr, e_wr;
    bit act, e_wv, e_wl;
    int ws;
    e_awr = '0; e_wr = '0; act = 1'b0; e_wv = 1'b0; e_wl = 1'b0; ws = 0;
    e_awv = 1'b0; e_awhs = 1'b0; e_whs = 1'b0; e_sel = 0;
    if (!rst) begin
      if (locked) e_sel = lock_idx;
      else begin
        e_sel = rr;
        for (int k = N - 1; k >= 0; k--) if (slv_aw_valid[(rr + k) % N]) e_sel = (rr + k) % N;
      end
      e_awv = (slv_aw_valid != '0) && (q.size() < D);
      if (mst_aw_ready && q.size() < D) e_awr[e_sel] = 1'b1;
      e_awhs = e_awv && mst_aw_ready;
      if (q.size() > 0) begin act = 1'b1; ws = q[0]; end
`ifdef AXI_WR_ARB_W_BYPASS_EN
      else if (e_awhs) begin act = 1'b1; ws = e_sel; end
`endif
      if (act) begin
        e_wv = slv_w_valid[ws];
        e_wl = slv_w_last[ws];
        if (mst_w_ready) e_wr[ws] = 1'b1;
      end
      e_whs = e_wv && e_wl && mst_w_ready;
    end
    chk("mst_aw_valid", 32'(mst_aw_valid), 32'(e_awv));
    chk("slv_aw_ready", 32'(slv_aw_ready), 32'(e_awr));
    chk("mst_w_valid",  32'(mst_w_valid),  32'(e_wv));
    chk("mst_w_last",   32'(mst_w_last),   32'(e_wl));
    chk("slv_w_ready",  32'(slv_w_ready),  32'(e_wr));
    chk("w_sel",        32'(w_sel),        32'(ws));
    chk("fifo_empty",   32'(w_fifo_empty), 32'(rst || q.size() == 0));
    chk("fifo_full",    32'(w_fifo_full),  32'(!rst && q.size() == D));
    if (rst || e_awv) chk("aw_sel", 32'(aw_sel), 32'(e_sel));
  endtask

  task automatic model_update();
    bit was_empty;
    if (rst) begin
      q.delete(); rr = 0; locked = 1'b0;
    end else begin
      was_empty = (q.size() == 0);
      if (e_whs && !was_empty) void'(q.pop_front());
      if (e_awhs) begin
        if (!(was_empty && e_whs)) q.push_back(e_sel);
        rr = (e_sel + 1) % N;
        locked = 1'b0;
      end else if (e_awv && !mst_aw_ready) begin
        locked = 1'b1; lock_idx = e_sel;
      end
    end
  endtask

  task automatic apply(input logic r, input logic [N-1:0] awv, input logic awr,
                       input logic [N-1:0] wv, input logic [N-1:0] wl, input logic wr);
    rst = r; slv_aw_valid = awv; mst_aw_ready = awr;
    slv_w_valid = wv; slv_w_last = wl; mst_w_ready = wr;
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    apply(1'b1, '0, 1'b0, '0, '0, 1'b0); advance();
  endtask

  initial begin
    // Reset with random inputs, then idle defaults
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, N'($urandom), 1'($urandom), N'($urandom), N'($urandom), 1'($urandom));
      advance();
    end
    apply(1'b0, '0, 1'b0, '0, '0, 1'b0);
    chk("rst_aw_sel", 32'(aw_sel), 32'd0);
    chk("rst_empty", 32'(w_fifo_empty), 32'd1);
    advance();

    // Round-robin with W draining so the FIFO never fills
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 4'hF, 1'b1, 4'hF, 4'hF, 1'b1);
      chk("rr_sel", 32'(aw_sel), 32'(k % N));
      chk("rr_ready", 32'(slv_aw_ready), 32'(4'b0001 << (k % N)));
      advance();
    end

    // Lock: requester 2 stalled while requester 0 joins
    do_reset();
    apply(1'b0, 4'b0100, 1'b0, '0, '0, 1'b0);
    chk("lock_sel0", 32'(aw_sel), 32'd2);
    advance();
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 4'b0101, 1'b0, '0, '0, 1'b0);
      chk("lock_sel", 32'(aw_sel), 32'd2);
      advance();
    end
    apply(1'b0, 4'b0101, 1'b1, '0, '0, 1'b0);
    chk("lock_hs", 32'(slv_aw_ready), 32'(4'b0100));
    advance();
    apply(1'b0, 4'b0001, 1'b1, '0, '0, 1'b0);
    chk("lock_next", 32'(aw_sel), 32'd0);
    advance();

    // Ordering: grants 1 then 3, two 4-beat bursts
    do_reset();
    apply(1'b0, 4'b0010, 1'b1, '0, '0, 1'b0);
    chk("ord_g1", 32'(aw_sel), 32'd1);
    advance();
    apply(1'b0, 4'b1000, 1'b1, '0, '0, 1'b0);
    chk("ord_g3", 32'(aw_sel), 32'd3);
    advance();
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, '0, 1'b0, 4'b1010, (i % 4 == 3) ? 4'b1010 : 4'b0000, 1'b1);
      chk("ord_wsel", 32'(w_sel), (i < 4) ? 32'd1 : 32'd3);
      chk("ord_wready", 32'(slv_w_ready), (i < 4) ? 32'(4'b0010) : 32'(4'b1000));
      advance();
    end
    apply(1'b0, '0, 1'b0, '0, '0, 1'b0);
    chk("ord_empty", 32'(w_fifo_empty), 32'd1);
    advance();

    // Full: four grants without W, then one last beat frees a slot
    do_reset();
    for (int k = 0; k < 4; k++) begin apply(1'b0, 4'hF, 1'b1, '0, '0, 1'b0); advance(); end
    apply(1'b0, 4'hF, 1'b1, '0, '0, 1'b0);
    chk("full_flag", 32'(w_fifo_full), 32'd1);
    chk("full_awv", 32'(mst_aw_valid), 32'd0);
    advance();
    apply(1'b0, 4'hF, 1'b1, 4'b0001, 4'b0001, 1'b1);
    chk("full_pop_rdy", 32'(slv_aw_ready), 32'd0);
    advance();
    apply(1'b0, 4'hF, 1'b1, '0, '0, 1'b0);
    chk("full_reopen", 32'(slv_aw_ready), 32'(4'b0001));
    advance();

    // Single-beat AW+W from requester 2
    do_reset();
    apply(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1);
    chk("byp_aw", 32'(slv_aw_ready), 32'(4'b0100));
`ifdef AXI_WR_ARB_W_BYPASS_EN
    chk("byp_w_same", 32'(slv_w_ready), 32'(4'b0100));
    advance();
`else
    chk("byp_w_none", 32'(mst_w_valid), 32'd0);
    advance();
    apply(1'b0, '0, 1'b0, 4'b0100, 4'b0100, 1'b1);
    chk("byp_w_next", 32'(slv_w_ready), 32'(4'b0100));
    advance();
`endif
    apply(1'b0, '0, 1'b0, '0, '0, 1'b0);
    chk("byp_empty", 32'(w_fifo_empty), 32'd1);
    advance();

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      apply(1'($urandom_range(0, 49) == 0), N'($urandom), 1'($urandom_range(0, 3) != 0),
            N'($urandom), N'($urandom) & N'($urandom), 1'($urandom_range(0, 2) != 0));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
